// File: rtl/fp_mul_rr_sched_if.sv
// Request/response bundle between the requester front-ends and the shared
// fp_mul scheduler; master = requesters plus consumer, slave = scheduler.
interface fp_mul_rr_sched_if #(
  parameter int NEXP  = 8,
  parameter int NSIG  = 23,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int NFLAG = 6
);
  localparam int W = NEXP + NSIG + 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_rnd;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_p;
  logic [NFLAG-1:0]  rsp_flags;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_rnd, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_flags, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rnd, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_flags, rsp_id
  );
endinterface

// File: rtl/fp_mul_rr_sched.sv
// Round-robin scheduler sharing one combinational fp_mul among NREQ requesters,
// with an operand register in front and a result register behind the multiplier.

module fp_mul #(
  parameter int NEXP  = 8,
  parameter int NSIG  = 23,
  parameter int NFLAG = 6
) (
  input  logic [NEXP+NSIG:0] a,
  input  logic [NEXP+NSIG:0] b,
  input  logic [2:0]         rnd,
  output logic [NEXP+NSIG:0] p,
  output logic [NFLAG-1:0]   flags
);
  localparam int PW   = 2 * (NSIG + 1);
  localparam int EMAX = (1 << NEXP) - 1;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int F_SNAN = 0, F_QNAN = 1, F_INF = 2, F_ZERO = 3, F_SUB = 4, F_NORM = 5;

  logic                 sgn, nanA, nanB, infA, infB, zeroA, zeroB, snanAny, guard;
  logic [NEXP-1:0]      expA, expB, expField, pExp;
  logic [NSIG-1:0]      fracA, fracB, pFrac;
  logic [PW-1:0]        prod, norm;
  logic [NEXP+NSIG-1:0] mag;
  int                   pos, eRes;

  always_comb begin
    sgn   = a[NEXP+NSIG] ^ b[NEXP+NSIG];
    expA  = a[NEXP+NSIG-1:NSIG];
    expB  = b[NEXP+NSIG-1:NSIG];
    fracA = a[NSIG-1:0];
    fracB = b[NSIG-1:0];
    nanA  = (&expA) & (|fracA);
    nanB  = (&expB) & (|fracB);
    infA  = (&expA) & ~(|fracA);
    infB  = (&expB) & ~(|fracB);
    zeroA = ~(|expA) & ~(|fracA);
    zeroB = ~(|expB) & ~(|fracB);
    snanAny = (nanA & ~fracA[NSIG-1]) | (nanB & ~fracB[NSIG-1]);

    prod = {{(NSIG+1){1'b0}}, |expA, fracA} * {{(NSIG+1){1'b0}}, |expB, fracB};
    pos = 0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (prod[i]) pos = int'(i);
    end

    // Exponent of the product once its leading one sits at the hidden-bit slot;
    // subnormal inputs use an effective exponent of 1.
    eRes = ((expA == '0) ? 1 : int'(expA)) + ((expB == '0) ? 1 : int'(expB))
           - BIAS + pos - 2 * NSIG;
    norm = prod << (PW - 1 - pos);
    expField = '0;
    if (eRes < 1) norm = norm >> (1 - eRes);
    else          expField = NEXP'(eRes);

    // Rounding carry ripples into the exponent field, covering subnormal->normal
    // and max-normal->infinity promotion.
    guard = norm[NSIG];
    mag   = {expField, norm[PW-2:NSIG+1]} + (NEXP+NSIG)'(rnd == 3'b100 && guard);

    if (nanA || nanB || (infA && zeroB) || (zeroA && infB))
      p = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
    else if (infA || infB)
      p = {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
    else if (prod == '0)
      p = {sgn, {(NEXP+NSIG){1'b0}}};
    else if (eRes > EMAX - 1)
      p = {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
    else
      p = {sgn, mag};

    pExp  = p[NEXP+NSIG-1:NSIG];
    pFrac = p[NSIG-1:0];
    flags = '0;
    flags[F_SNAN] = snanAny;
    if (&pExp) begin
      if (|pFrac) flags[F_QNAN] = 1'b1;
      else        flags[F_INF]  = 1'b1;
    end else if (pExp == '0) begin
      if (|pFrac) flags[F_SUB]  = 1'b1;
      else        flags[F_ZERO] = 1'b1;
    end else begin
      flags[F_NORM] = 1'b1;
    end
  end
endmodule

module fp_mul_rr_sched #(
  parameter int NEXP  = 8,
  parameter int NSIG  = 23,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int NFLAG = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_mul_rr_sched_if.slave     bus,
  output logic                 busy
);
  localparam int W = NEXP + NSIG + 1;

  logic             adv1, adv2, grantHit, accept, s1Valid;
  logic [IDW-1:0]   grantIdx, rrPtr, s1Id;
  logic [W-1:0]     s1A, s1B, mulP;
  logic [2:0]       s1Rnd;
  logic [NFLAG-1:0] mulFlags;
  int unsigned      arbIdx;

  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    arbIdx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      arbIdx = (32'(rrPtr) + k) % NREQ;
      if (!grantHit && bus.req_valid[arbIdx]) begin
        grantHit = 1'b1;
        grantIdx = IDW'(arbIdx);
      end
    end
  end

  // req_ready is forced low during reset even though both stages look empty.
  always_comb begin
    adv2   = !bus.rsp_valid || bus.rsp_ready;
    adv1   = !s1Valid || adv2;
    accept = rst_n && adv1 && grantHit;
    bus.req_ready = '0;
    if (accept) bus.req_ready[grantIdx] = 1'b1;
    busy = s1Valid || bus.rsp_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1A     <= '0;
      s1B     <= '0;
      s1Rnd   <= '0;
      s1Id    <= '0;
      rrPtr   <= IDW'(NREQ - 1);
    end else if (adv1) begin
      s1Valid <= accept;
      if (accept) begin
        s1A   <= bus.req_a[grantIdx*W +: W];
        s1B   <= bus.req_b[grantIdx*W +: W];
        s1Rnd <= bus.req_rnd[grantIdx*3 +: 3];
        s1Id  <= grantIdx;
        rrPtr <= grantIdx;
      end
    end
  end

  fp_mul #(.NEXP(NEXP), .NSIG(NSIG), .NFLAG(NFLAG)) uMul (
    .a     (s1A),
    .b     (s1B),
    .rnd   (s1Rnd),
    .p     (mulP),
    .flags (mulFlags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_p     <= '0;
      bus.rsp_flags <= '0;
      bus.rsp_id    <= '0;
    end else if (adv2) begin
      bus.rsp_valid <= s1Valid;
      bus.rsp_p     <= mulP;
      bus.rsp_flags <= mulFlags;
      bus.rsp_id    <= s1Id;
    end
  end
endmodule

// File: tb/tb_fp_mul_rr_sched.sv
// Directed bench for fp_mul_rr_sched: accepted requests are scored against an
// independent binary32 multiply model and checked in order as responses drain.
module tb_fp_mul_rr_sched;
  localparam int QN = 1, SN = 0, INF = 2, ZR = 3, NRM = 5;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
    logic [5:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  always #5 clk = ~clk;

  fp_mul_rr_sched_if #(.NEXP(8), .NSIG(23), .NREQ(4), .IDW(2), .NFLAG(6)) bus ();

  fp_mul_rr_sched #(.NEXP(8), .NSIG(23), .NREQ(4), .IDW(2), .NFLAG(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          accCnt = 0;
  int          rspCnt = 0;
  logic [3:0]  lastGrant;
  logic [31:0] gotP[4];
  logic [5:0]  gotF[4];

  function automatic logic [37:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] rnd);
    logic        nanA, nanB, infA, infB, zA, zB, s, g;
    logic [47:0] pr;
    logic [31:0] r;
    logic [5:0]  f;
    logic [22:0] m;
    logic [30:0] mag;
    int          e;
    nanA = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nanB = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    infA = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    infB = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    zA   = (a[30:0] == 0);
    zB   = (b[30:0] == 0);
    s    = a[31] ^ b[31];
    f    = '0;
    if (nanA || nanB || (infA && zB) || (zA && infB)) begin
      r = 32'h7FC00000;
      f[QN] = 1'b1;
      f[SN] = (nanA && !a[22]) || (nanB && !b[22]);
    end else if (infA || infB) begin
      r = {s, 8'hFF, 23'h0};
      f[INF] = 1'b1;
    end else if (zA || zB) begin
      r = {s, 31'h0};
      f[ZR] = 1'b1;
    end else begin
      pr = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (pr[47]) begin
        e++;
        m = pr[46:24];
        g = pr[23];
      end else begin
        m = pr[45:23];
        g = pr[22];
      end
      mag = {e[7:0], m} + {30'h0, (rnd == 3'b100) && g};
      r   = {s, mag};
      f[NRM] = 1'b1;
    end
    return {f, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic setSlot(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rnd);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_rnd[i*3 +: 3] = rnd;
  endtask

  // Sample handshakes on the falling edge; they take effect on the next rising edge.
  task automatic tick();
    exp_t        e;
    logic [37:0] r;
    @(negedge clk);
    chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
    lastGrant = bus.req_ready & bus.req_valid;
    if (bus.rsp_valid && bus.rsp_ready) begin
      rspCnt++;
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rsp observed id=%0d p=%0h expected no response",
               bus.rsp_id, bus.rsp_p);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_p", 64'(bus.rsp_p), 64'(e.p));
        chk("rsp_flags", 64'(bus.rsp_flags), 64'(e.flags));
        gotP[e.id] = bus.rsp_p;
        gotF[e.id] = bus.rsp_flags;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (lastGrant[i]) begin
        r = refMul(bus.req_a[i*32 +: 32], bus.req_b[i*32 +: 32], bus.req_rnd[i*3 +: 3]);
        e.id = 2'(i);
        e.p = r[31:0];
        e.flags = r[37:32];
        sbq.push_back(e);
        accCnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && (sbq.size() != 0 || busy); n++) tick();
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] refP0;
    int          accBefore, rspBefore;

    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_rnd = '0;
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_p", 64'(bus.rsp_p), 64'd0);
    chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operation, latency of two edges
    gotP = '{default: 'x};
    setSlot(0, 32'h3FC00000, 32'h40000000, 3'b000);
    bus.req_valid = 4'b0001;
    tick();
    chk("single_grant", 64'(lastGrant), 64'h1);
    bus.req_valid = '0;
    chk("lat_after_n", 64'(bus.rsp_valid), 64'd0);
    chk("busy_s1", 64'(busy), 64'd1);
    tick();
    chk("lat_after_n1", 64'(bus.rsp_valid), 64'd1);
    drain();
    chk("single_p", 64'(gotP[0]), 64'h40400000);
    chk("single_normal", 64'(gotF[0][NRM]), 64'd1);

    // Special cases from requester 2
    setSlot(2, 32'h7F800000, 32'h00000000, 3'b000);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    drain();
    chk("inf_x_zero_p", 64'(gotP[2]), 64'h7FC00000);
    chk("inf_x_zero_qnan", 64'(gotF[2][QN]), 64'd1);
    setSlot(2, 32'hBF800000, 32'h7F800000, 3'b000);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    drain();
    chk("neg_inf_p", 64'(gotP[2]), 64'hFF800000);
    chk("neg_inf_flag", 64'(gotF[2][INF]), 64'd1);

    // Leave the pointer at 3 so the next sweep starts at requester 0
    setSlot(3, 32'h3F800000, 32'h3F800000, 3'b000);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    drain();

    // Round-robin with all requesters valid
    for (int i = 0; i < 4; i++)
      setSlot(i, 32'h3F800000 + (i << 20), 32'h40000000 + (i << 21) + i, 3'b000);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_grant", 64'(lastGrant), 64'(1 << (k % 4)));
    end
    bus.req_valid = '0;
    drain();

    // Backpressure: two slots fill, then the arbiter stalls
    refP0 = refMul(bus.req_a[31:0], bus.req_b[31:0], 3'b000) & 32'hFFFFFFFF;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    accBefore = accCnt;
    tick();
    tick();
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    tick();
    chk("bp_stall_grant", 64'(lastGrant), 64'd0);
    chk("bp_hold_p", 64'(bus.rsp_p), 64'(refP0));
    tick();
    chk("bp_stall_grant2", 64'(lastGrant), 64'd0);
    chk("bp_hold_p2", 64'(bus.rsp_p), 64'(refP0));
    chk("bp_hold_id", 64'(bus.rsp_id), 64'd0);
    chk("bp_accepts", 64'(accCnt - accBefore), 64'd2);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    rspBefore = rspCnt;
    drain();
    chk("bp_rsp_count", 64'(rspCnt - rspBefore), 64'd2);

    // Asynchronous reset with both stages occupied
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    sbq.delete();
    setSlot(1, 32'h40400000, 32'h40800000, 3'b000);
    setSlot(3, 32'h40A00000, 32'h3F000000, 3'b000);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    chk("postrst_grant", 64'(lastGrant), 64'h2);
    bus.req_valid = '0;
    chk("postrst_no_stale", 64'(bus.rsp_valid), 64'd0);
    drain();

    // Rounding mode travels with its operands
    gotP = '{default: 'x};
    setSlot(1, 32'h3FC00001, 32'h3F800001, 3'b100);
    setSlot(3, 32'h3FC00001, 32'h3F800001, 3'b000);
    bus.req_valid = 4'b1010;
    tick();
    tick();
    bus.req_valid = '0;
    drain();
    chk("rnd_half_up", 64'(gotP[1]), 64'h3FC00003);
    chk("rnd_trunc", 64'(gotP[3]), 64'h3FC00002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mul_rr_sched.md
Name: fp_mul_rr_sched

Overview:
- Shares one combinational fp_mul datapath (class decode, significand multiply, round, pack) among NREQ requesters.
- Arbitration is round-robin.
- Two register stages: an operand register in front of fp_mul and a result register behind it.
- Results return on a single response channel, tagged with the requester index, with valid/ready backpressure.
- Sits between the vector/accumulator front-ends and the fp_mul instance. It is the only block that drives fp_mul operands.

Parameters:
- NEXP, 8, exponent width passed to fp_mul
- NSIG, 23, stored significand width passed to fp_mul
- NREQ, 4, number of requesters, 2..16
- IDW, $clog2(NREQ), width of requester tag
- NFLAG, 6, width of IEEE-754 class flag vector (LAST_FLAG)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit set
- req_a  in  NREQ*(NEXP+NSIG+1)  packed operand A; slot i at bits [i*W +: W]
- req_b  in  NREQ*(NEXP+NSIG+1)  packed operand B; same packing
- req_rnd  in  NREQ*3  packed rounding mode; 3'b100 = round-half-up, others = truncate
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_p  out  NEXP+NSIG+1  product
- rsp_flags  out  NFLAG  fp_mul class flags (SNAN/QNAN/INFINITY/ZERO/SUBNORMAL/NORMAL)
- rsp_id  out  IDW  requester index that issued the result
- busy  out  1  s1_valid | rsp_valid

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, rsp_valid=0, rsp_p=0, rsp_flags=0, rsp_id=0, rr_ptr=NREQ-1, req_ready=0, busy=0. All of these hold while rst_n=0.
- Reset mid-operation: in-flight transactions are discarded with no response. After release, the first grant goes to the lowest-index valid requester.
- Stage enables:
  - adv2 = !rsp_valid | rsp_ready
  - adv1 = !s1_valid | adv2
- Arbitration is combinational:
  - Search starts at (rr_ptr+1) mod NREQ and wraps upward.
  - The first i with req_valid[i]=1 is granted.
  - req_ready = onehot(grant) when adv1=1, else 0.
  - req_ready never depends on req_a, req_b or req_rnd.
- Accept: a handshake occurs when req_valid[i] & req_ready[i]. On that edge:
  - s1 captures a, b, rnd and id=i, and sets s1_valid=1.
  - rr_ptr is set to i.
  - rr_ptr changes only on an accept.
- S1 drain without refill: if adv1=1 and no request is accepted, s1_valid clears.
- fp_mul is instantiated with the s1 operands (NEXP, NSIG forwarded).
- Result register: when adv2=1 it loads rsp_p/rsp_flags from fp_mul and rsp_id from s1_id, and rsp_valid takes s1_valid.
- Output hold: while rsp_valid=1 and rsp_ready=0, rsp_p, rsp_flags and rsp_id hold stable.
- Latency: a request accepted at edge N has rsp_valid=1 after edge N+1. Throughput is 1 result/cycle with rsp_ready held high.
- Capacity: at most 2 transactions in flight. While both stages are full and rsp_ready=0, all req_ready=0.
- Requester rule: operands must hold stable while req_valid=1 and req_ready=0. The scheduler does not check this.
- req_valid may drop without a handshake. The arbiter re-evaluates every cycle with no lock.
- Simultaneous accept and response drain in the same cycle is legal and loses nothing.
- Single requester: it is granted every cycle it is valid, provided adv1=1.
- Wrap-around: with rr_ptr=NREQ-1 the search starts at 0.
- Responses come back in acceptance order. rsp_id identifies the owner. There is no reordering.

Test Plan:
- Single op: req 0 sends a=0x3FC00000, b=0x40000000, rnd=0, rsp_ready=1. Expect rsp_valid two edges after accept, rsp_p=0x40400000, NORMAL flag set, rsp_id=0.
- Special case: req 2 sends a=0x7F800000 (+inf), b=0x00000000. Expect rsp_p=0x7FC00000, QNAN flag set, rsp_id=2. Then a=0xBF800000, b=0x7F800000: expect 0xFF800000 with INFINITY flag set.
- Round-robin: all 4 req_valid held high with distinct operands, rsp_ready=1, for 8 cycles. Expect grant order and rsp_id sequence 0,1,2,3,0,1,2,3, with exactly one req_ready bit per cycle.
- Backpressure: continuous requests with rsp_ready=0 for 4 cycles. Expect exactly 2 accepts, then req_ready=0. rsp_p/rsp_id stay stable. Restoring rsp_ready yields both results in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 ops in flight, between clock edges. Expect rsp_valid=0 and busy=0 immediately. After release, no stale response appears, and with reqs 1 and 3 valid the first grant goes to 1.
- Rounding pass-through: same operands sent by req 1 with rnd=3'b100 and by req 3 with rnd=3'b000. Expect each rsp_p to match the standalone fp_mul model for its own rnd, proving rnd travels with its operands.
